// File: rtl/wb_host_master.sv
// ----------------------------------------------------------------------------
// wb_host_master
//
// Wishbone classic initiator for bring-up. It turns a valid/ready command
// stream into single Wishbone read or write cycles. It bounds the wait for ack
// with a timeout and returns the read data and error status on a valid/ready
// response stream. It also counts completed and timed-out transactions.
//
// Parameters
//   TIMEOUT    cycles with cyc/stb asserted before the cycle is aborted
//              (legal range 2..65535)
//   CNT_W      width of txn_count / err_count
//
// Ports
//   wb_clk_i, wb_rst_ni     clock, asynchronous active-low reset
//   cmd_valid/cmd_ready     command handshake
//   cmd_we/adr/dat/sel      command payload (write enable, byte address,
//                           write data, byte lanes)
//   rsp_valid/rsp_ready     response handshake
//   rsp_dat, rsp_err        read data (0 for writes and errors), timeout flag
//   wbm_*                   Wishbone classic initiator port
//   txn_count, err_count    completed / timed-out transaction counters
//
// Every output is driven directly from a flop. That includes cmd_ready,
// which is recomputed from the next state so that it is always in line with
// the state register.
// ----------------------------------------------------------------------------
module wb_host_master #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_ni,

   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_we,
   input  logic [31:0]      cmd_adr,
   input  logic [31:0]      cmd_dat,
   input  logic [3:0]       cmd_sel,

   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [31:0]      rsp_dat,
   output logic             rsp_err,

   output logic             wbm_cyc_o,
   output logic             wbm_stb_o,
   output logic             wbm_we_o,
   output logic [3:0]       wbm_sel_o,
   output logic [31:0]      wbm_adr_o,
   output logic [31:0]      wbm_dat_o,
   input  logic             wbm_ack_i,
   input  logic [31:0]      wbm_dat_i,

   output logic [CNT_W-1:0] txn_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUS  = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   // The timeout counter holds the index of the current BUS cycle, starting
   // at 0. An abort on the edge that ends cycle TIMEOUT-1 keeps cyc high for
   // exactly TIMEOUT cycles.
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic [1:0]       state_q,     state_d;
   logic             cmd_ready_q, cmd_ready_d;
   logic             cyc_q,       cyc_d;
   logic             we_q,        we_d;
   logic [3:0]       sel_q,       sel_d;
   logic [31:0]      adr_q,       adr_d;
   logic [31:0]      wdat_q,      wdat_d;
   logic [15:0]      tmo_q,       tmo_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic [31:0]      rsp_dat_q,   rsp_dat_d;
   logic             rsp_err_q,   rsp_err_d;
   logic [CNT_W-1:0] txn_q,       txn_d;
   logic [CNT_W-1:0] err_q,       err_d;

   // -------------------------------------------------------------------------
   // Next-state logic
   // -------------------------------------------------------------------------
   always_comb begin
      // NOTE: every signal gets a hold-value default first. Then a path that
      // does not assign a signal cannot infer a latch.
      state_d     = state_q;
      cyc_d       = cyc_q;
      we_d        = we_q;
      sel_d       = sel_q;
      adr_d       = adr_q;
      wdat_d      = wdat_q;
      tmo_d       = tmo_q;
      rsp_valid_d = rsp_valid_q;
      rsp_dat_d   = rsp_dat_q;
      rsp_err_d   = rsp_err_q;
      txn_d       = txn_q;
      err_d       = err_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready_q) begin
               we_d    = cmd_we;
               sel_d   = cmd_sel;
               adr_d   = cmd_adr;
               wdat_d  = cmd_dat;
               cyc_d   = 1'b1;
               tmo_d   = '0;
               state_d = ST_BUS;
            end
         end

         ST_BUS: begin
            // Ack takes priority, so an ack on the last allowed cycle still
            // completes the transaction without an error.
            if (wbm_ack_i) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b0;
               rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
               txn_d       = txn_q + CNT_ONE;
               state_d     = ST_RESP;
            end else if (tmo_q == TMO_LAST) begin
               cyc_d       = 1'b0;
               rsp_valid_d = 1'b1;
               rsp_err_d   = 1'b1;
               rsp_dat_d   = 32'd0;
               txn_d       = txn_q + CNT_ONE;
               err_d       = err_q + CNT_ONE;
               state_d     = ST_RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
         end

         ST_RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end

         default: begin
            cyc_d       = 1'b0;
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase

      // cmd_ready is taken from the next state. Its flop then always matches
      // the state register without a combinational decode on the output.
      cmd_ready_d = (state_d == ST_IDLE);
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
      if (!wb_rst_ni) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         cyc_q       <= 1'b0;
         we_q        <= 1'b0;
         sel_q       <= '0;
         adr_q       <= '0;
         wdat_q      <= '0;
         tmo_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_dat_q   <= '0;
         rsp_err_q   <= 1'b0;
         txn_q       <= '0;
         err_q       <= '0;
      end else begin
         // NOTE: flops use non-blocking assignments. All registers then
         // update together from values taken before the edge.
         state_q     <= state_d;
         cmd_ready_q <= cmd_ready_d;
         cyc_q       <= cyc_d;
         we_q        <= we_d;
         sel_q       <= sel_d;
         adr_q       <= adr_d;
         wdat_q      <= wdat_d;
         tmo_q       <= tmo_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_dat_q   <= rsp_dat_d;
         rsp_err_q   <= rsp_err_d;
         txn_q       <= txn_d;
         err_q       <= err_d;
      end
   end

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign cmd_ready = cmd_ready_q;
   assign wbm_cyc_o = cyc_q;
   assign wbm_stb_o = cyc_q;   // classic single cycles: stb always equals cyc
   assign wbm_we_o  = we_q;
   assign wbm_sel_o = sel_q;
   assign wbm_adr_o = adr_q;
   assign wbm_dat_o = wdat_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_dat   = rsp_dat_q;
   assign rsp_err   = rsp_err_q;
   assign txn_count = txn_q;
   assign err_count = err_q;

endmodule
